// File: rtl/error_resilient_pkg.sv
// Shared FSM encoding and default parameter constants for the
// timing-error recovery controller and its rate monitor.
package error_resilient_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_STALL  = 2'd1,
        ST_REPLAY = 2'd2
    } state_e;

    localparam int DEF_DATA_WIDTH   = 3;
    localparam int DEF_STALL_CYCLES = 2;
    localparam int DEF_WINDOW       = 64;
    localparam int DEF_ERR_THRESH   = 4;
    localparam int DEF_CNT_WIDTH    = 8;

    // Wide enough for the largest legal stall length (15).
    localparam int STALL_CNT_W = 4;

endpackage

// File: rtl/error_rate_monitor.sv
// Error-rate observation window: counts accepted errors per window and
// issues one-cycle slow/fast clock-scaling requests at each window wrap.
module error_rate_monitor
    import error_resilient_pkg::*;
#(
    parameter int WINDOW     = DEF_WINDOW,
    parameter int ERR_THRESH = DEF_ERR_THRESH
) (
    input  logic clk,
    input  logic rst,
    input  logic err_accept,
    output logic slow_req,
    output logic fast_req
);

    localparam int WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int EW    = $clog2(ERR_THRESH + 1);

    logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
    logic [EW-1:0]    win_err_q, win_err_d;
    logic             slow_q, slow_d;
    logic             fast_q, fast_d;

    function automatic logic [EW-1:0] sat_inc_thresh(input logic [EW-1:0] v);
        return (v >= EW'(ERR_THRESH)) ? v : v + EW'(1);
    endfunction

    always_comb begin
        win_cnt_d = win_cnt_q + WIN_W'(1);
        win_err_d = err_accept ? sat_inc_thresh(win_err_q) : win_err_q;
        slow_d    = 1'b0;
        fast_d    = 1'b0;
        // The decision includes an error accepted in the wrap cycle itself.
        if (win_cnt_q == WIN_W'(WINDOW - 1)) begin
            win_cnt_d = '0;
            slow_d    = (win_err_d >= EW'(ERR_THRESH));
            fast_d    = (win_err_d == '0);
            win_err_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            win_cnt_q <= '0;
            win_err_q <= '0;
            slow_q    <= 1'b0;
            fast_q    <= 1'b0;
        end else begin
            win_cnt_q <= win_cnt_d;
            win_err_q <= win_err_d;
            slow_q    <= slow_d;
            fast_q    <= fast_d;
        end
    end

    assign slow_req = slow_q;
    assign fast_req = fast_q;

endmodule

// File: rtl/error_recovery_ctrl.sv
// Razor-style recovery controller: on a timing error it commits the shadow
// value, stalls upstream for STALL_CYCLES, replays once, then resumes.
module error_recovery_ctrl
    import error_resilient_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int STALL_CYCLES = DEF_STALL_CYCLES,
    parameter int WINDOW       = DEF_WINDOW,
    parameter int ERR_THRESH   = DEF_ERR_THRESH,
    parameter int CNT_WIDTH    = DEF_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] d_main,
    input  logic [DATA_WIDTH-1:0] d_shadow,
    input  logic                  error,
    input  logic                  clr_count,
    output logic [DATA_WIDTH-1:0] q,
    output logic                  q_valid,
    output logic                  stall,
    output logic                  replay,
    output logic [CNT_WIDTH-1:0]  err_count,
    output logic                  slow_req,
    output logic                  fast_req
);

    state_e                  state_q, state_d;
    logic [STALL_CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [DATA_WIDTH-1:0]   q_q, q_d;
    logic                    q_valid_q, q_valid_d;
    logic                    stall_q, stall_d;
    logic                    replay_q, replay_d;
    logic [CNT_WIDTH-1:0]    err_count_q, err_count_d;
    logic                    err_accept;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    always_comb begin
        state_d     = state_q;
        stall_cnt_d = stall_cnt_q;
        q_d         = q_q;
        q_valid_d   = q_valid_q;
        stall_d     = stall_q;
        replay_d    = replay_q;
        err_accept  = 1'b0;

        case (state_q)
            ST_RUN: begin
                replay_d = 1'b0;
                if (error) begin
                    err_accept  = 1'b1;
                    q_d         = d_shadow;
                    q_valid_d   = 1'b0;
                    stall_d     = 1'b1;
                    stall_cnt_d = STALL_CNT_W'(STALL_CYCLES);
                    state_d     = ST_STALL;
                end else begin
                    q_d       = d_main;
                    q_valid_d = 1'b1;
                    stall_d   = 1'b0;
                end
            end
            // q keeps the captured shadow value through STALL into REPLAY.
            ST_STALL: begin
                if (stall_cnt_q <= STALL_CNT_W'(1)) begin
                    q_valid_d = 1'b1;
                    stall_d   = 1'b0;
                    replay_d  = 1'b1;
                    state_d   = ST_REPLAY;
                end else begin
                    stall_cnt_d = stall_cnt_q - STALL_CNT_W'(1);
                    q_valid_d   = 1'b0;
                    stall_d     = 1'b1;
                end
            end
            ST_REPLAY: begin
                q_d       = d_main;
                q_valid_d = 1'b1;
                stall_d   = 1'b0;
                replay_d  = 1'b0;
                state_d   = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        if (clr_count) begin
            err_count_d = '0;
        end else if (err_accept) begin
            err_count_d = sat_inc(err_count_q);
        end else begin
            err_count_d = err_count_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            stall_cnt_q <= '0;
            q_q         <= '0;
            q_valid_q   <= 1'b0;
            stall_q     <= 1'b0;
            replay_q    <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            q_q         <= q_d;
            q_valid_q   <= q_valid_d;
            stall_q     <= stall_d;
            replay_q    <= replay_d;
            err_count_q <= err_count_d;
        end
    end

    error_rate_monitor #(
        .WINDOW     (WINDOW),
        .ERR_THRESH (ERR_THRESH)
    ) u_rate_mon (
        .clk        (clk),
        .rst        (rst),
        .err_accept (err_accept),
        .slow_req   (slow_req),
        .fast_req   (fast_req)
    );

    assign q         = q_q;
    assign q_valid   = q_valid_q;
    assign stall     = stall_q;
    assign replay    = replay_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_error_recovery_ctrl.sv
// Directed bench for error_recovery_ctrl with a 2-bit error counter so that
// saturation is reachable; other parameters stay at their defaults.
module tb_error_recovery_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] d_main;
    logic [2:0] d_shadow;
    logic       error;
    logic       clr_count;
    logic [2:0] q;
    logic       q_valid;
    logic       stall;
    logic       replay;
    logic [1:0] err_count;
    logic       slow_req;
    logic       fast_req;

    int n_tests = 0;
    int n_fail  = 0;

    error_recovery_ctrl #(
        .DATA_WIDTH   (3),
        .STALL_CYCLES (2),
        .WINDOW       (64),
        .ERR_THRESH   (4),
        .CNT_WIDTH    (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .d_main    (d_main),
        .d_shadow  (d_shadow),
        .error     (error),
        .clr_count (clr_count),
        .q         (q),
        .q_valid   (q_valid),
        .stall     (stall),
        .replay    (replay),
        .err_count (err_count),
        .slow_req  (slow_req),
        .fast_req  (fast_req)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; error = 1'b0; clr_count = 1'b0; d_main = 3'd0; d_shadow = 3'd0;
        step();
        step();
        chk("rst_q",       32'(q),         0);
        chk("rst_q_valid", 32'(q_valid),   0);
        chk("rst_stall",   32'(stall),     0);
        chk("rst_replay",  32'(replay),    0);
        chk("rst_errcnt",  32'(err_count), 0);
        chk("rst_slow",    32'(slow_req),  0);
        chk("rst_fast",    32'(fast_req),  0);
        rst = 1'b0;

        // error-free ramp: q follows d_main one edge later
        for (int i = 0; i < 8; i++) begin
            d_main = 3'(i);
            step();
            chk("ramp_q",       32'(q),       32'(i));
            chk("ramp_q_valid", 32'(q_valid), 1);
            chk("ramp_stall",   32'(stall),   0);
        end

        // single error: d_main=3, d_shadow=5
        d_main = 3'd3; d_shadow = 3'd5; error = 1'b1;
        step();
        chk("err1_q",       32'(q),       5);
        chk("err1_q_valid", 32'(q_valid), 0);
        chk("err1_stall",   32'(stall),   1);
        chk("err1_replay",  32'(replay),  0);
        error = 1'b0; d_main = 3'd6;
        step();
        chk("err2_stall",   32'(stall),   1);
        chk("err2_q",       32'(q),       5);
        chk("err2_q_valid", 32'(q_valid), 0);
        step();
        chk("rep_replay",  32'(replay),    1);
        chk("rep_q",       32'(q),         5);
        chk("rep_q_valid", 32'(q_valid),   1);
        chk("rep_stall",   32'(stall),     0);
        chk("rep_errcnt",  32'(err_count), 1);
        step();
        chk("post_replay",  32'(replay),  0);
        chk("post_q",       32'(q),       6);
        chk("post_q_valid", 32'(q_valid), 1);

        clr_count = 1'b1;
        step();
        clr_count = 1'b0;
        chk("clr_errcnt", 32'(err_count), 0);

        // error held 10 cycles: accepted on steps 1, 5, 9 only
        error = 1'b1;
        for (int s = 1; s <= 10; s++) begin
            step();
            chk("hold_stall",  32'(stall),  ((s % 4) == 1 || (s % 4) == 2) ? 1 : 0);
            chk("hold_replay", 32'(replay), ((s % 4) == 3) ? 1 : 0);
        end
        error = 1'b0;
        step();
        step();
        chk("hold_errcnt", 32'(err_count), 3);

        // a fourth accepted error must not wrap the 2-bit counter
        error = 1'b1;
        step();
        error = 1'b0;
        step();
        step();
        step();
        chk("sat_errcnt", 32'(err_count), 3);

        // clear and accepted error on the same edge: clear wins, FSM still stalls
        error = 1'b1; clr_count = 1'b1;
        step();
        error = 1'b0; clr_count = 1'b0;
        chk("clrerr_errcnt", 32'(err_count), 0);
        chk("clrerr_stall",  32'(stall),     1);
        step();
        step();
        step();

        // reset in the middle of STALL
        error = 1'b1; d_shadow = 3'd6;
        step();
        error = 1'b0;
        step();
        chk("mid_stall", 32'(stall), 1);
        rst = 1'b1; d_main = 3'd7;
        step();
        chk("mrst_q",       32'(q),         0);
        chk("mrst_q_valid", 32'(q_valid),   0);
        chk("mrst_stall",   32'(stall),     0);
        chk("mrst_replay",  32'(replay),    0);
        chk("mrst_errcnt",  32'(err_count), 0);
        chk("mrst_slow",    32'(slow_req),  0);
        chk("mrst_fast",    32'(fast_req),  0);
        rst = 1'b0; d_main = 3'd2;
        step();
        chk("after_rst_q",       32'(q),       2);
        chk("after_rst_q_valid", 32'(q_valid), 1);
        chk("after_rst_stall",   32'(stall),   0);

        // window test, edges counted from a fresh reset (window counter 0)
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int e = 1; e <= 63; e++) begin
            error = (e <= 13);
            step();
            chk("win1_slow", 32'(slow_req), 0);
            chk("win1_fast", 32'(fast_req), 0);
        end
        error = 1'b0;
        step();
        chk("wrap1_slow", 32'(slow_req), 1);
        chk("wrap1_fast", 32'(fast_req), 0);
        chk("win1_errcnt", 32'(err_count), 3);
        step();
        chk("wrap1_slow_drop", 32'(slow_req), 0);
        for (int e = 66; e <= 127; e++) begin
            step();
            chk("win2_fast", 32'(fast_req), 0);
        end
        step();
        chk("wrap2_fast", 32'(fast_req), 1);
        chk("wrap2_slow", 32'(slow_req), 0);
        step();
        chk("wrap2_fast_drop", 32'(fast_req), 0);

        // three errors (one below threshold): neither request at the wrap
        for (int e = 130; e <= 191; e++) begin
            error = (e <= 138);
            step();
        end
        error = 1'b0;
        step();
        chk("wrap3_slow", 32'(slow_req), 0);
        chk("wrap3_fast", 32'(fast_req), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
